// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: default 640x480@60 geometry,
// line/frame total helpers and the sync polarity type.
package video_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_X_WIDTH   = 12;
  localparam int DEF_Y_WIDTH   = 12;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } pol_t;

  function automatic int h_total(input int visible, input int front, input int sync,
                                 input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front, input int sync,
                                 input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Position counter that steps on advance and rolls from MAX back to 0.
// wrap flags the advancing cycle that performs the roll-over.
module video_timing_counter #(
  parameter int MAX   = 799,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  if (MAX < 0 || WIDTH < 1 || WIDTH > 32 ||
      longint'(MAX) >= (longint'(1) << WIDTH)) begin : g_bad_counter
    $error("video_timing_counter: MAX must be non-negative and fit in WIDTH bits");
  end

  assign wrap = advance && (count == LAST);

  // clear beats advance so a disabled generator always sits at the origin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI transmit path: registered syncs, data enable,
// pixel coordinates and line/frame start strobes decoded from the next-position counters.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter pol_t H_POL     = POL_ACTIVE_LOW,
  parameter pol_t V_POL     = POL_ACTIVE_LOW,
  parameter int   X_WIDTH   = DEF_X_WIDTH,
  parameter int   Y_WIDTH   = DEF_Y_WIDTH
) (
  input  logic               reset_n,
  input  logic               clk,
  input  logic               enable,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic [X_WIDTH-1:0] out_x,
  output logic [Y_WIDTH-1:0] out_y,
  output logic               out_line_start,
  output logic               out_frame_start
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_geometry
    $error("video_timing_gen: every porch, sync and visible size must be at least 1");
  end

  if (X_WIDTH < 1 || X_WIDTH > 32 ||
      longint'(H_TOTAL) > (longint'(1) << X_WIDTH)) begin : g_bad_x_width
    $error("video_timing_gen: X_WIDTH cannot hold H_TOTAL-1");
  end

  if (Y_WIDTH < 1 || Y_WIDTH > 32 ||
      longint'(V_TOTAL) > (longint'(1) << Y_WIDTH)) begin : g_bad_y_width
    $error("video_timing_gen: Y_WIDTH cannot hold V_TOTAL-1");
  end

  localparam logic [X_WIDTH-1:0] H_VIS_END = X_WIDTH'(H_VISIBLE);
  localparam logic [X_WIDTH-1:0] HS_START  = X_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [X_WIDTH-1:0] HS_END    = X_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] V_VIS_END = Y_WIDTH'(V_VISIBLE);
  localparam logic [Y_WIDTH-1:0] VS_START  = Y_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [Y_WIDTH-1:0] VS_END    = Y_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic H_ACT = H_POL;
  localparam logic V_ACT = V_POL;

  logic [X_WIDTH-1:0] h_cnt;
  logic [Y_WIDTH-1:0] v_cnt;
  logic               h_wrap;
  logic               unused_v_wrap;

  logic               de_d;
  logic               hs_act_d;
  logic               vs_act_d;
  logic               line_start_d;
  logic               frame_start_d;

  video_timing_counter #(
    .MAX   (H_TOTAL - 1),
    .WIDTH (X_WIDTH)
  ) u_h_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (~enable),
    .advance (enable),
    .count   (h_cnt),
    .wrap    (h_wrap)
  );

  // the vertical counter only moves on a line roll-over, so vsync edges land on h==0
  video_timing_counter #(
    .MAX   (V_TOTAL - 1),
    .WIDTH (Y_WIDTH)
  ) u_v_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (~enable),
    .advance (h_wrap),
    .count   (v_cnt),
    .wrap    (unused_v_wrap)
  );

  always_comb begin
    de_d          = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_act_d      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act_d      = (v_cnt >= VS_START) && (v_cnt < VS_END);
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_hsync       <= ~H_ACT;
      out_vsync       <= ~V_ACT;
      out_de          <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
    end else if (!enable) begin
      out_hsync       <= ~H_ACT;
      out_vsync       <= ~V_ACT;
      out_de          <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      out_hsync       <= hs_act_d ? H_ACT : ~H_ACT;
      out_vsync       <= vs_act_d ? V_ACT : ~V_ACT;
      out_de          <= de_d;
      out_x           <= h_cnt;
      out_y           <= v_cnt;
      out_line_start  <= line_start_d;
      out_frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, enable and reset behaviour,
// a scaled 24x19 mode for whole-frame statistics, and the 7x5 active-high mode.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [11:0] x_a, y_a;
  logic        rst_b, en_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [4:0]  x_b, y_b;
  logic        rst_c, en_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [2:0]  x_c, y_c;

  int n_checks = 0;
  int n_fail   = 0;

  video_timing_gen dut_a (
    .reset_n(rst_a), .clk(clk), .enable(en_a), .out_hsync(hs_a), .out_vsync(vs_a),
    .out_de(de_a), .out_x(x_a), .out_y(y_a), .out_line_start(ls_a), .out_frame_start(fs_a)
  );

  video_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .X_WIDTH(5), .Y_WIDTH(5)
  ) dut_b (
    .reset_n(rst_b), .clk(clk), .enable(en_b), .out_hsync(hs_b), .out_vsync(vs_b),
    .out_de(de_b), .out_x(x_b), .out_y(y_b), .out_line_start(ls_b), .out_frame_start(fs_b)
  );

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(POL_ACTIVE_HIGH), .V_POL(POL_ACTIVE_HIGH),
    .X_WIDTH(3), .Y_WIDTH(3)
  ) dut_c (
    .reset_n(rst_c), .clk(clk), .enable(en_c), .out_hsync(hs_c), .out_vsync(vs_c),
    .out_de(de_c), .out_x(x_c), .out_y(y_c), .out_line_start(ls_c), .out_frame_start(fs_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; en_a = 1'b0;
    repeat (3) tick();
    n_checks++; if (de_a !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", de_a); end
    n_checks++; if (hs_a !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hs_a); end
    n_checks++; if (vs_a !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vs_a); end
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin n_fail++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", x_a, y_a); end
    n_checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got ls=%b fs=%b want 0 0", ls_a, fs_a); end
    rst_a = 1'b1; en_a = 1'b1;
    tick();
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin n_fail++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", x_a, y_a); end
    n_checks++; if (de_a !== 1'b1 || ls_a !== 1'b1 || fs_a !== 1'b1) begin n_fail++; $display("FAIL first_flags: got de=%b ls=%b fs=%b want 1 1 1", de_a, ls_a, fs_a); end
  endtask

  task automatic test_h_timing();
    int de_cnt = 0;
    int hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      de_cnt += int'(de_a);
      hs_low += int'(!hs_a);
      n_checks++; if (x_a !== 12'(i) || y_a !== 12'd0) begin n_fail++; $display("FAIL h_pos: got (%0d,%0d) want (%0d,0)", x_a, y_a, i); end
      n_checks++; if (de_a !== logic'(i < 640)) begin n_fail++; $display("FAIL h_de x=%0d: got %b want %b", i, de_a, i < 640); end
      n_checks++; if (hs_a !== logic'(!(i >= 656 && i < 752))) begin n_fail++; $display("FAIL h_hsync x=%0d: got %b want %b", i, hs_a, !(i >= 656 && i < 752)); end
      n_checks++; if (ls_a !== logic'(i == 0) || fs_a !== logic'(i == 0)) begin n_fail++; $display("FAIL h_strobes x=%0d: got ls=%b fs=%b", i, ls_a, fs_a); end
      n_checks++; if (vs_a !== 1'b1) begin n_fail++; $display("FAIL h_vsync x=%0d: got %b want 1", i, vs_a); end
    end
    n_checks++; if (de_cnt != 640) begin n_fail++; $display("FAIL line_de_count: got %0d want 640", de_cnt); end
    n_checks++; if (hs_low != 96) begin n_fail++; $display("FAIL line_hsync_count: got %0d want 96", hs_low); end
    tick();
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd1) begin n_fail++; $display("FAIL line1_pos: got (%0d,%0d) want (0,1)", x_a, y_a); end
    n_checks++; if (ls_a !== 1'b1 || fs_a !== 1'b0) begin n_fail++; $display("FAIL line1_strobes: got ls=%b fs=%b want 1 0", ls_a, fs_a); end
  endtask

  task automatic test_enable_drop();
    int guard = 0;
    while (!(x_a == 12'd100 && y_a == 12'd2) && guard < 3000) begin
      tick();
      guard++;
    end
    n_checks++; if (x_a !== 12'd100 || y_a !== 12'd2) begin n_fail++; $display("FAIL en_reach: got (%0d,%0d) want (100,2) after %0d cycles", x_a, y_a, guard); end
    n_checks++; if (de_a !== 1'b1) begin n_fail++; $display("FAIL en_pre_de: got %b want 1", de_a); end
    en_a = 1'b0;
    tick();
    n_checks++; if (de_a !== 1'b0 || hs_a !== 1'b1 || vs_a !== 1'b1) begin n_fail++; $display("FAIL en_off_levels: got de=%b hs=%b vs=%b want 0 1 1", de_a, hs_a, vs_a); end
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0) begin n_fail++; $display("FAIL en_off_pos: got (%0d,%0d) want (0,0)", x_a, y_a); end
    n_checks++; if (ls_a !== 1'b0 || fs_a !== 1'b0) begin n_fail++; $display("FAIL en_off_strobes: got ls=%b fs=%b want 0 0", ls_a, fs_a); end
    tick();
    en_a = 1'b1;
    tick();
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0 || fs_a !== 1'b1 || de_a !== 1'b1) begin n_fail++; $display("FAIL reen_first: got (%0d,%0d) fs=%b de=%b want (0,0) 1 1", x_a, y_a, fs_a, de_a); end
    tick();
    n_checks++; if (x_a !== 12'd1 || y_a !== 12'd0 || fs_a !== 1'b0) begin n_fail++; $display("FAIL reen_second: got (%0d,%0d) fs=%b want (1,0) 0", x_a, y_a, fs_a); end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (x_a != 12'd700 && guard < 1000) begin
      tick();
      guard++;
    end
    n_checks++; if (x_a !== 12'd700 || hs_a !== 1'b0) begin n_fail++; $display("FAIL ar_reach: got x=%0d hs=%b want 700 0", x_a, hs_a); end
    #3;
    rst_a = 1'b0;
    #1;
    n_checks++; if (hs_a !== 1'b1) begin n_fail++; $display("FAIL ar_hsync: got %b want 1", hs_a); end
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0 || de_a !== 1'b0) begin n_fail++; $display("FAIL ar_pos: got (%0d,%0d) de=%b want (0,0) 0", x_a, y_a, de_a); end
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    tick();
    n_checks++; if (x_a !== 12'd0 || y_a !== 12'd0 || fs_a !== 1'b1 || de_a !== 1'b1) begin n_fail++; $display("FAIL ar_restart: got (%0d,%0d) fs=%b de=%b want (0,0) 1 1", x_a, y_a, fs_a, de_a); end
    tick();
    n_checks++; if (x_a !== 12'd1 || fs_a !== 1'b0) begin n_fail++; $display("FAIL ar_step: got x=%0d fs=%b want 1 0", x_a, fs_a); end
  endtask

  task automatic test_frame_scaled();
    int cycles = 0, de_cnt = 0, ls_cnt = 0, fs_cnt = 0, vs_cnt = 0, vs_runs = 0, de_bad = 0;
    int vs_sx = -1, vs_sy = -1, vs_ex = -1, vs_ey = -1;
    logic prev_vs;
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    n_checks++; if (fs_b !== 1'b1 || x_b !== 5'd0 || y_b !== 5'd0) begin n_fail++; $display("FAIL fr_first: got fs=%b (%0d,%0d) want 1 (0,0)", fs_b, x_b, y_b); end
    prev_vs = vs_b;
    do begin
      de_cnt += int'(de_b);
      ls_cnt += int'(ls_b);
      fs_cnt += int'(fs_b);
      if (de_b && y_b >= 5'd12) de_bad++;
      if (!vs_b) begin
        vs_cnt++;
        if (prev_vs) begin vs_runs++; vs_sx = int'(x_b); vs_sy = int'(y_b); end
        vs_ex = int'(x_b); vs_ey = int'(y_b);
      end
      prev_vs = vs_b;
      tick();
      cycles++;
    end while (!fs_b && cycles < 2000);
    n_checks++; if (cycles != 456) begin n_fail++; $display("FAIL fr_period: got %0d want 456", cycles); end
    n_checks++; if (de_cnt != 192) begin n_fail++; $display("FAIL fr_de_count: got %0d want 192", de_cnt); end
    n_checks++; if (ls_cnt != 19) begin n_fail++; $display("FAIL fr_line_starts: got %0d want 19", ls_cnt); end
    n_checks++; if (fs_cnt != 1) begin n_fail++; $display("FAIL fr_frame_starts: got %0d want 1", fs_cnt); end
    n_checks++; if (vs_cnt != 48 || vs_runs != 1) begin n_fail++; $display("FAIL fr_vsync_len: got %0d cycles in %0d runs want 48 in 1", vs_cnt, vs_runs); end
    n_checks++; if (vs_sx != 0 || vs_sy != 14) begin n_fail++; $display("FAIL fr_vsync_start: got (%0d,%0d) want (0,14)", vs_sx, vs_sy); end
    n_checks++; if (vs_ex != 23 || vs_ey != 15) begin n_fail++; $display("FAIL fr_vsync_end: got (%0d,%0d) want (23,15)", vs_ex, vs_ey); end
    n_checks++; if (de_bad != 0) begin n_fail++; $display("FAIL fr_de_blank_lines: got %0d want 0", de_bad); end
    n_checks++; if (x_b !== 5'd0 || y_b !== 5'd0) begin n_fail++; $display("FAIL fr_wrap_pos: got (%0d,%0d) want (0,0)", x_b, y_b); end
  endtask

  task automatic test_small_mode();
    rst_c = 1'b1; en_c = 1'b1;
    tick();
    for (int c = 0; c < 35; c++) begin
      if (c > 0) tick();
      n_checks++; if (x_c !== 3'(c % 7) || y_c !== 3'(c / 7)) begin n_fail++; $display("FAIL sm_pos c=%0d: got (%0d,%0d) want (%0d,%0d)", c, x_c, y_c, c % 7, c / 7); end
      n_checks++; if (hs_c !== logic'(c % 7 == 5)) begin n_fail++; $display("FAIL sm_hsync c=%0d: got %b", c, hs_c); end
      n_checks++; if (vs_c !== logic'(c / 7 == 3)) begin n_fail++; $display("FAIL sm_vsync c=%0d: got %b", c, vs_c); end
      n_checks++; if (de_c !== logic'(c % 7 < 4 && c / 7 < 2)) begin n_fail++; $display("FAIL sm_de c=%0d: got %b", c, de_c); end
      n_checks++; if (ls_c !== logic'(c % 7 == 0) || fs_c !== logic'(c == 0)) begin n_fail++; $display("FAIL sm_strobes c=%0d: got ls=%b fs=%b", c, ls_c, fs_c); end
    end
    tick();
    n_checks++; if (x_c !== 3'd0 || y_c !== 3'd0 || fs_c !== 1'b1) begin n_fail++; $display("FAIL sm_wrap: got (%0d,%0d) fs=%b want (0,0) 1", x_c, y_c, fs_c); end
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;
    test_reset();
    test_h_timing();
    test_enable_drop();
    test_async_reset();
    test_frame_scaled();
    test_small_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
